// File: rtl/cook_timer_pkg.sv
// Shared types, constants and BCD arithmetic helpers for the cook timer.
// The +30 s helper exists only when COOK_TIMER_ADD30_EN is defined.
package cook_timer_pkg;

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        ENTRY = 2'd0,
        RUN   = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Display order, most significant digit first: mm:ss.
    typedef struct packed {
        bcd_t min_tens;
        bcd_t min_ones;
        bcd_t sec_tens;
        bcd_t sec_ones;
    } count_t;

    localparam bcd_t BCD_MAX      = 4'd9;
    localparam bcd_t SEC_TENS_MAX = 4'd5;
    localparam bcd_t ADD_SEC_TENS = 4'd3;

    // True when the count shows 00:00.
    function automatic logic count_is_zero(input count_t c);
        return (c == 16'h0000);
    endfunction

    // One-second BCD decrement. Seconds tens borrow wraps to 5, so an
    // entered 00:99 walks down through 00:90 .. 00:00 as 99 real seconds.
    // A zero count is returned unchanged rather than wrapping to 99:59.
    function automatic count_t bcd_dec(input count_t c);
        count_t r;
        r = c;
        if (count_is_zero(c)) begin
            r = c;
        end else if (c.sec_ones != 4'd0) begin
            r.sec_ones = c.sec_ones - 4'd1;
        end else begin
            r.sec_ones = BCD_MAX;
            if (c.sec_tens != 4'd0) begin
                r.sec_tens = c.sec_tens - 4'd1;
            end else begin
                r.sec_tens = SEC_TENS_MAX;
                if (c.min_ones != 4'd0) begin
                    r.min_ones = c.min_ones - 4'd1;
                end else begin
                    r.min_ones = BCD_MAX;
                    r.min_tens = c.min_tens - 4'd1;
                end
            end
        end
        return r;
    endfunction

`ifdef COOK_TIMER_ADD30_EN
    // Add 30 s by adding 3 to the seconds tens. A carry out of the seconds
    // tens bumps the minutes in BCD; at 99 minutes the carry would be lost,
    // so the whole add is dropped and the count returned unchanged.
    function automatic count_t bcd_add30(input count_t c);
        count_t     r;
        logic [4:0] s;
        r = c;
        s = {1'b0, c.sec_tens} + {1'b0, ADD_SEC_TENS};
        if (s >= 5'd6) begin
            if ((c.min_tens == BCD_MAX) && (c.min_ones == BCD_MAX)) begin
                r = c;
            end else begin
                r.sec_tens = bcd_t'(s - 5'd6);
                if (c.min_ones == BCD_MAX) begin
                    r.min_ones = 4'd0;
                    r.min_tens = c.min_tens + 4'd1;
                end else begin
                    r.min_ones = c.min_ones + 4'd1;
                end
            end
        end else begin
            r.sec_tens = s[3:0];
        end
        return r;
    endfunction
`endif

endpackage

// File: rtl/cook_timer_if.sv
// Keypad / magnetron / display bundle of the cook timer.
// The add30 strobe is present only when COOK_TIMER_ADD30_EN is defined.
interface cook_timer_if;
    import cook_timer_pkg::*;

    logic clearn;
    logic load;
    bcd_t digit;
    logic mag_on;
`ifdef COOK_TIMER_ADD30_EN
    logic add30;
`endif
    bcd_t min_tens;
    bcd_t min_ones;
    bcd_t sec_tens;
    bcd_t sec_ones;
    logic timer_done;

`ifdef COOK_TIMER_ADD30_EN
    modport master (
        output clearn, load, digit, mag_on, add30,
        input  min_tens, min_ones, sec_tens, sec_ones, timer_done
    );
    modport slave (
        input  clearn, load, digit, mag_on, add30,
        output min_tens, min_ones, sec_tens, sec_ones, timer_done
    );
`else
    modport master (
        output clearn, load, digit, mag_on,
        input  min_tens, min_ones, sec_tens, sec_ones, timer_done
    );
    modport slave (
        input  clearn, load, digit, mag_on,
        output min_tens, min_ones, sec_tens, sec_ones, timer_done
    );
`endif

endinterface

// File: rtl/cook_timer_tick_prescaler.sv
// One-second tick generator: counts 0..TICK_DIV-1 while enabled and pulses
// tick on the last count. Dropping enable returns the count to 0, so every
// new enable period waits a full TICK_DIV cycles before the first tick.
module tick_prescaler #(
    parameter int TICK_DIV = 100
) (
    input  logic clk,
    input  logic rstn,
    input  logic enable,
    output logic tick
);

    localparam int                CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_r;

    // Free-running modulo-TICK_DIV counter, held at 0 while disabled.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_r <= '0;
        end else if (!enable) begin
            cnt_r <= '0;
        end else if (cnt_r == LAST) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    assign tick = enable && (cnt_r == LAST);

endmodule

// File: rtl/cook_timer.sv
// Microwave cook timer: keypad-loaded mm:ss BCD countdown, decremented once
// per tick while the magnetron latch (mag_on) is set.
// Optional feature macro: COOK_TIMER_ADD30_EN adds the +30 s strobe.
module cook_timer
    import cook_timer_pkg::*;
#(
    parameter int TICK_DIV = 100
) (
    input  logic     clk,
    input  logic     rstn,
    cook_timer_if.slave tif
);

    state_t state_r;
    count_t count_r;

    logic   presc_en_s;
    logic   tick_s;
    logic   zero_s;
    count_t shift_s;
    count_t dec_base_s;
    count_t run_next_s;
`ifdef COOK_TIMER_ADD30_EN
    count_t entry_add_s;
`endif

    // The prescaler only runs in RUN; clearn stops it on the same edge so it
    // reads 0 together with the cleared digits.
    assign presc_en_s = (state_r == RUN) && tif.clearn;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_presc (
        .clk    (clk),
        .rstn   (rstn),
        .enable (presc_en_s),
        .tick   (tick_s)
    );

    assign zero_s = count_is_zero(count_r);

    // Next-count candidates: keypad shift for ENTRY, tick/add result for RUN.
    always_comb begin
        shift_s = '{min_tens: count_r.min_ones,
                    min_ones: count_r.sec_tens,
                    sec_tens: count_r.sec_ones,
                    sec_ones: tif.digit};
        if (tick_s && tif.mag_on) begin
            dec_base_s = bcd_dec(count_r);
        end else begin
            dec_base_s = count_r;
        end
`ifdef COOK_TIMER_ADD30_EN
        entry_add_s = bcd_add30(count_r);
        if (tif.add30) begin
            run_next_s = bcd_add30(dec_base_s);
        end else begin
            run_next_s = dec_base_s;
        end
`else
        run_next_s = dec_base_s;
`endif
    end

    // Timer FSM and digit registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ENTRY;
            count_r <= '0;
        end else if (!tif.clearn) begin
            state_r <= ENTRY;
            count_r <= '0;
        end else begin
            case (state_r)
                ENTRY: begin
`ifdef COOK_TIMER_ADD30_EN
                    if (tif.add30) begin
                        count_r <= entry_add_s;
                        state_r <= ENTRY;
                    end else
`endif
                    if (tif.load) begin
                        // A digit above 9 is a keypad glitch: keep the count.
                        if (tif.digit <= BCD_MAX) begin
                            count_r <= shift_s;
                        end else begin
                            count_r <= count_r;
                        end
                        state_r <= ENTRY;
                    end else if (tif.mag_on && !zero_s) begin
                        state_r <= RUN;
                    end else begin
                        state_r <= ENTRY;
                    end
                end
                RUN: begin
                    count_r <= run_next_s;
                    if (!tif.mag_on) begin
                        state_r <= HOLD;
                    end else if (count_is_zero(run_next_s)) begin
                        state_r <= ENTRY;
                    end else begin
                        state_r <= RUN;
                    end
                end
                HOLD: begin
                    count_r <= count_r;
                    if (tif.mag_on) begin
                        state_r <= RUN;
                    end else begin
                        state_r <= HOLD;
                    end
                end
                default: begin
                    state_r <= ENTRY;
                    count_r <= '0;
                end
            endcase
        end
    end

    assign tif.min_tens   = count_r.min_tens;
    assign tif.min_ones   = count_r.min_ones;
    assign tif.sec_tens   = count_r.sec_tens;
    assign tif.sec_ones   = count_r.sec_ones;
    assign tif.timer_done = zero_s;

endmodule

// File: tb/tb_cook_timer.sv
// Directed bench for cook_timer with TICK_DIV = 4. Inputs change 1 time
// unit after a rising edge; outputs are sampled at the same point.
module tb_cook_timer;
    import cook_timer_pkg::*;

    logic clk;
    logic rstn;
    int   pass_cnt;
    int   total_cnt;

    cook_timer_if tif ();

    cook_timer #(
        .TICK_DIV (4)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .tif  (tif.slave)
    );

    logic [15:0] disp;
    assign disp = {tif.min_tens, tif.min_ones, tif.sec_tens, tif.sec_ones};

    always #5 clk = ~clk;

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load_digit(input logic [3:0] d);
        tif.load  = 1'b1;
        tif.digit = d;
        cycles(1);
        tif.load  = 1'b0;
        tif.digit = 4'd0;
    endtask

    task automatic do_clear();
        tif.clearn = 1'b0;
        cycles(1);
        tif.clearn = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        #3;
        total_cnt++;
        if (disp !== 16'h0000) $display("FAIL reset_digits got %h exp %h", disp, 16'h0000);
        else pass_cnt++;
        total_cnt++;
        if (tif.timer_done !== 1'b1) $display("FAIL reset_done got %b exp %b", tif.timer_done, 1'b1);
        else pass_cnt++;
        total_cnt++;
        if (dut.state_r !== ENTRY) $display("FAIL reset_state got %0d exp %0d", dut.state_r, ENTRY);
        else pass_cnt++;
        cycles(2);
        rstn = 1'b1;
        cycles(1);
    endtask

    task automatic test_entry();
        load_digit(4'd1);
        total_cnt++;
        if (disp !== 16'h0001) $display("FAIL entry_first got %h exp %h", disp, 16'h0001);
        else pass_cnt++;
        load_digit(4'd3);
        load_digit(4'd0);
        load_digit(4'hA);
        total_cnt++;
        if (disp !== 16'h0130) $display("FAIL entry_digits got %h exp %h", disp, 16'h0130);
        else pass_cnt++;
        total_cnt++;
        if (tif.timer_done !== 1'b0) $display("FAIL entry_done got %b exp %b", tif.timer_done, 1'b0);
        else pass_cnt++;
        tif.mag_on = 1'b1;
        cycles(1);
        total_cnt++;
        if (dut.state_r !== RUN) $display("FAIL entry_to_run got %0d exp %0d", dut.state_r, RUN);
        else pass_cnt++;
        cycles(3);
        total_cnt++;
        if (disp !== 16'h0130) $display("FAIL entry_no_early_tick got %h exp %h", disp, 16'h0130);
        else pass_cnt++;
        cycles(1);
        total_cnt++;
        if (disp !== 16'h0129) $display("FAIL entry_first_dec got %h exp %h", disp, 16'h0129);
        else pass_cnt++;
        cycles(4);
        total_cnt++;
        if (disp !== 16'h0128) $display("FAIL entry_second_dec got %h exp %h", disp, 16'h0128);
        else pass_cnt++;
        tif.mag_on = 1'b0;
        cycles(1);
        do_clear();
    endtask

    task automatic test_finish();
        load_digit(4'd0);
        load_digit(4'd2);
        tif.mag_on = 1'b1;
        cycles(5);
        total_cnt++;
        if (disp !== 16'h0001) $display("FAIL finish_one got %h exp %h", disp, 16'h0001);
        else pass_cnt++;
        cycles(3);
        total_cnt++;
        if (tif.timer_done !== 1'b0) $display("FAIL finish_done_early got %b exp %b", tif.timer_done, 1'b0);
        else pass_cnt++;
        cycles(1);
        total_cnt++;
        if (disp !== 16'h0000) $display("FAIL finish_zero got %h exp %h", disp, 16'h0000);
        else pass_cnt++;
        total_cnt++;
        if (tif.timer_done !== 1'b1) $display("FAIL finish_done got %b exp %b", tif.timer_done, 1'b1);
        else pass_cnt++;
        total_cnt++;
        if (dut.state_r !== ENTRY) $display("FAIL finish_state got %0d exp %0d", dut.state_r, ENTRY);
        else pass_cnt++;
        cycles(8);
        total_cnt++;
        if (disp !== 16'h0000 || dut.state_r !== ENTRY)
            $display("FAIL finish_stays got %h/%0d exp %h/%0d", disp, dut.state_r, 16'h0000, ENTRY);
        else pass_cnt++;
        tif.mag_on = 1'b0;
        cycles(1);
    endtask

    task automatic test_pause();
        load_digit(4'd1);
        load_digit(4'd0);
        tif.mag_on = 1'b1;
        cycles(5);
        total_cnt++;
        if (disp !== 16'h0009) $display("FAIL pause_run got %h exp %h", disp, 16'h0009);
        else pass_cnt++;
        cycles(1);
        tif.mag_on = 1'b0;
        cycles(1);
        total_cnt++;
        if (dut.state_r !== HOLD) $display("FAIL pause_hold got %0d exp %0d", dut.state_r, HOLD);
        else pass_cnt++;
        cycles(10);
        load_digit(4'd7);
        total_cnt++;
        if (disp !== 16'h0009) $display("FAIL pause_frozen got %h exp %h", disp, 16'h0009);
        else pass_cnt++;
        tif.mag_on = 1'b1;
        cycles(4);
        total_cnt++;
        if (disp !== 16'h0009) $display("FAIL pause_resume_wait got %h exp %h", disp, 16'h0009);
        else pass_cnt++;
        cycles(1);
        total_cnt++;
        if (disp !== 16'h0008) $display("FAIL pause_resume_dec got %h exp %h", disp, 16'h0008);
        else pass_cnt++;
        // Drop mag_on so that it is low exactly on the next tick edge.
        cycles(3);
        tif.mag_on = 1'b0;
        cycles(1);
        total_cnt++;
        if (disp !== 16'h0008 || dut.state_r !== HOLD)
            $display("FAIL pause_tick_edge got %h/%0d exp %h/%0d", disp, dut.state_r, 16'h0008, HOLD);
        else pass_cnt++;
        do_clear();
        total_cnt++;
        if (dut.state_r !== ENTRY || disp !== 16'h0000)
            $display("FAIL pause_clear got %h/%0d exp %h/%0d", disp, dut.state_r, 16'h0000, ENTRY);
        else pass_cnt++;
    endtask

    task automatic test_clear();
        load_digit(4'd4);
        load_digit(4'd5);
        tif.mag_on = 1'b1;
        cycles(2);
        tif.clearn = 1'b0;
        tif.load   = 1'b1;
        tif.digit  = 4'd3;
        cycles(1);
        total_cnt++;
        if (disp !== 16'h0000) $display("FAIL clear_digits got %h exp %h", disp, 16'h0000);
        else pass_cnt++;
        total_cnt++;
        if (tif.timer_done !== 1'b1) $display("FAIL clear_done got %b exp %b", tif.timer_done, 1'b1);
        else pass_cnt++;
        total_cnt++;
        if (dut.state_r !== ENTRY) $display("FAIL clear_state got %0d exp %0d", dut.state_r, ENTRY);
        else pass_cnt++;
        total_cnt++;
        if (dut.u_presc.cnt_r !== 2'd0) $display("FAIL clear_presc got %0d exp %0d", dut.u_presc.cnt_r, 0);
        else pass_cnt++;
        tif.clearn = 1'b1;
        tif.load   = 1'b0;
        tif.digit  = 4'd0;
        tif.mag_on = 1'b0;
        cycles(1);
    endtask

    task automatic test_async_reset();
        load_digit(4'd3);
        tif.mag_on = 1'b1;
        cycles(2);
        #2;
        rstn = 1'b0;
        #1;
        total_cnt++;
        if (disp !== 16'h0000 || tif.timer_done !== 1'b1)
            $display("FAIL async_rst got %h/%b exp %h/%b", disp, tif.timer_done, 16'h0000, 1'b1);
        else pass_cnt++;
        total_cnt++;
        if (dut.state_r !== ENTRY) $display("FAIL async_rst_state got %0d exp %0d", dut.state_r, ENTRY);
        else pass_cnt++;
        tif.mag_on = 1'b0;
        rstn = 1'b1;
        cycles(1);
    endtask

`ifdef COOK_TIMER_ADD30_EN
    task automatic pulse_add30();
        tif.add30 = 1'b1;
        cycles(1);
        tif.add30 = 1'b0;
    endtask

    task automatic test_add30();
        load_digit(4'd4);
        load_digit(4'd5);
        pulse_add30();
        total_cnt++;
        if (disp !== 16'h0115) $display("FAIL add30_45 got %h exp %h", disp, 16'h0115);
        else pass_cnt++;
        do_clear();
        load_digit(4'd9);
        load_digit(4'd9);
        pulse_add30();
        total_cnt++;
        if (disp !== 16'h0169) $display("FAIL add30_99s got %h exp %h", disp, 16'h0169);
        else pass_cnt++;
        do_clear();
        load_digit(4'd9);
        load_digit(4'd9);
        load_digit(4'd4);
        load_digit(4'd5);
        pulse_add30();
        total_cnt++;
        if (disp !== 16'h9945) $display("FAIL add30_sat got %h exp %h", disp, 16'h9945);
        else pass_cnt++;
        do_clear();
        load_digit(4'd1);
        tif.load  = 1'b1;
        tif.digit = 4'd5;
        pulse_add30();
        tif.load  = 1'b0;
        total_cnt++;
        if (disp !== 16'h0031) $display("FAIL add30_over_load got %h exp %h", disp, 16'h0031);
        else pass_cnt++;
        tif.mag_on = 1'b1;
        cycles(4);
        pulse_add30();
        total_cnt++;
        if (disp !== 16'h0100) $display("FAIL add30_on_tick got %h exp %h", disp, 16'h0100);
        else pass_cnt++;
        tif.mag_on = 1'b0;
        cycles(1);
        do_clear();
    endtask
`endif

    initial begin
        clk        = 1'b0;
        rstn       = 1'b0;
        pass_cnt   = 0;
        total_cnt  = 0;
        tif.clearn = 1'b1;
        tif.load   = 1'b0;
        tif.digit  = 4'd0;
        tif.mag_on = 1'b0;
`ifdef COOK_TIMER_ADD30_EN
        tif.add30  = 1'b0;
`endif
        test_reset();
        test_entry();
        test_finish();
        test_pause();
        test_clear();
        test_async_reset();
`ifdef COOK_TIMER_ADD30_EN
        test_add30();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
